// File: rtl/spi_flash_responder_pkg.sv
// Shared constants and types for the SPI NOR-flash responder.
// Opcodes, FSM state encoding and the fixed status byte live here.
package spi_flash_responder_pkg;

    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_FREAD    = 8'h0B;
    localparam logic [7:0] OP_RDSR     = 8'h05;
    localparam logic [7:0] STATUS_BYTE = 8'h00;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DUMMY  = 3'd3,
        DATA   = 3'd4,
        STATUS = 3'd5,
        IGNORE = 3'd6
    } state_t;

    // 24-bit flash address increment, wrapping 0xFFFFFF -> 0x000000.
    function automatic logic [23:0] next_addr(input logic [23:0] a);
        return a + 24'd1;
    endfunction

endpackage

// File: rtl/spi_flash_responder_spi_in_sync.sv
// Synchronizers for cs_n/sclk/mosi plus one-cycle sclk rise/fall strobes.
// All outputs are registered and mutually aligned.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n_raw,
    input  logic sclk_raw,
    input  logic mosi_raw,
    output logic cs_n_sync,
    output logic mosi_sync,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_prev;

    // Synchronizer chains and edge detection on the last sclk stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_pipe   <= {SYNC_STAGES{1'b1}};
            sclk_pipe <= {SYNC_STAGES{1'b0}};
            mosi_pipe <= {SYNC_STAGES{1'b0}};
            sclk_prev <= 1'b0;
            cs_n_sync <= 1'b1;
            mosi_sync <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n_raw};
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk_raw};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi_raw};
            sclk_prev <= sclk_pipe[SYNC_STAGES-1];
            cs_n_sync <= cs_pipe[SYNC_STAGES-1];
            mosi_sync <= mosi_pipe[SYNC_STAGES-1];
            sclk_rise <= sclk_pipe[SYNC_STAGES-1] & ~sclk_prev;
            sclk_fall <= ~sclk_pipe[SYNC_STAGES-1] & sclk_prev;
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash responder: READ, FAST_READ and RDSR served
// from a byte-wide memory port with single-byte prefetch.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_dat_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);

    logic        cs_n_s;
    logic        mosi_s;
    logic        rise_raw_s;
    logic        fall_raw_s;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .cs_n_raw  (spi_cs_n),
        .sclk_raw  (spi_sclk),
        .mosi_raw  (spi_mosi),
        .cs_n_sync (cs_n_s),
        .mosi_sync (mosi_s),
        .sclk_rise (rise_raw_s),
        .sclk_fall (fall_raw_s)
    );

    state_t      state_r, state_nxt;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt;
    logic [1:0]  byte_cnt_r, byte_cnt_nxt;
    logic [7:0]  shift_r, shift_nxt;
    logic [23:0] addr_r, addr_nxt;
    logic        dummy_r, dummy_nxt;
    logic [7:0]  tx_r, tx_nxt;
    logic [7:0]  pf_r, pf_nxt;
    logic        pf_valid_r, pf_valid_nxt;
    logic        stale_r, stale_nxt;
    logic        miso_nxt, oe_nxt, rd_nxt, busy_nxt;
    logic [ADDR_W-1:0] adr_nxt;

    logic        rise_s, fall_s, ack_s;
    logic [7:0]  rx_byte_s, fetched_s;
    logic [23:0] shift_addr_s, inc_addr_s;

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt    = state_r;
        bit_cnt_nxt  = bit_cnt_r;
        byte_cnt_nxt = byte_cnt_r;
        shift_nxt    = shift_r;
        addr_nxt     = addr_r;
        dummy_nxt    = dummy_r;
        tx_nxt       = tx_r;
        pf_nxt       = pf_r;
        pf_valid_nxt = pf_valid_r;
        stale_nxt    = stale_r;
        miso_nxt     = spi_miso;
        oe_nxt       = spi_miso_oe;
        rd_nxt       = mem_rd_o;
        adr_nxt      = mem_adr_o;
        busy_nxt     = ~cs_n_s;

        rise_s       = rise_raw_s & ~cs_n_s;
        fall_s       = fall_raw_s & ~cs_n_s;
        ack_s        = mem_rd_o & mem_ack_i;
        rx_byte_s    = {shift_r[6:0], mosi_s};
        shift_addr_s = {addr_r[22:0], mosi_s};
        inc_addr_s   = next_addr(addr_r);
        // A load that beats the ack (or an ack landing on the load cycle) is covered here.
        fetched_s    = pf_valid_r ? pf_r : ((ack_s & ~stale_r) ? mem_dat_i : FILL_BYTE);

        if (ack_s) begin
            rd_nxt    = 1'b0;
            stale_nxt = 1'b0;
            pf_nxt    = stale_r ? pf_r : mem_dat_i;
            pf_valid_nxt = ~stale_r;
        end else begin
            rd_nxt    = mem_rd_o;
        end

        case (state_r)
            IDLE: begin
                if (!cs_n_s) begin
                    state_nxt    = CMD;
                    bit_cnt_nxt  = 3'd0;
                    byte_cnt_nxt = 2'd0;
                end else begin
                    state_nxt    = IDLE;
                end
            end
            CMD: begin
                if (rise_s) begin
                    shift_nxt   = rx_byte_s;
                    bit_cnt_nxt = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        byte_cnt_nxt = 2'd0;
                        case (rx_byte_s)
                            OP_READ:  begin state_nxt = ADDR; dummy_nxt = 1'b0; end
                            OP_FREAD: begin state_nxt = ADDR; dummy_nxt = 1'b1; end
                            OP_RDSR:  begin state_nxt = STATUS; tx_nxt = STATUS_BYTE; oe_nxt = 1'b1; end
                            default:  begin state_nxt = IGNORE; oe_nxt = 1'b0; end
                        endcase
                    end else begin
                        state_nxt = CMD;
                    end
                end else begin
                    state_nxt = CMD;
                end
            end
            ADDR: begin
                if (rise_s) begin
                    addr_nxt    = shift_addr_s;
                    bit_cnt_nxt = bit_cnt_r + 3'd1;
                    if ((bit_cnt_r == 3'd7) && (byte_cnt_r == 2'd2)) begin
                        state_nxt    = dummy_r ? DUMMY : DATA;
                        byte_cnt_nxt = 2'd0;
                        rd_nxt       = 1'b1;
                        adr_nxt      = shift_addr_s[ADDR_W-1:0];
                        pf_valid_nxt = 1'b0;
                        stale_nxt    = 1'b0;
                    end else begin
                        byte_cnt_nxt = (bit_cnt_r == 3'd7) ? byte_cnt_r + 2'd1 : byte_cnt_r;
                    end
                end else begin
                    state_nxt = ADDR;
                end
            end
            DUMMY: begin
                if (rise_s) begin
                    bit_cnt_nxt = bit_cnt_r + 3'd1;
                    state_nxt   = (bit_cnt_r == 3'd7) ? DATA : DUMMY;
                end else begin
                    state_nxt   = DUMMY;
                end
            end
            DATA: begin
                if (fall_s) begin
                    bit_cnt_nxt = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd0) begin
                        miso_nxt     = fetched_s[7];
                        tx_nxt       = {fetched_s[6:0], 1'b1};
                        oe_nxt       = 1'b1;
                        addr_nxt     = inc_addr_s;
                        rd_nxt       = 1'b1;
                        adr_nxt      = inc_addr_s[ADDR_W-1:0];
                        pf_valid_nxt = 1'b0;
                        stale_nxt    = 1'b0;
                    end else begin
                        miso_nxt = tx_r[7];
                        tx_nxt   = {tx_r[6:0], 1'b1};
                    end
                end else begin
                    state_nxt = DATA;
                end
            end
            STATUS: begin
                if (fall_s) begin
                    bit_cnt_nxt = bit_cnt_r + 3'd1;
                    miso_nxt    = (bit_cnt_r == 3'd0) ? STATUS_BYTE[7] : tx_r[7];
                    tx_nxt      = (bit_cnt_r == 3'd0) ? {STATUS_BYTE[6:0], 1'b0} : {tx_r[6:0], 1'b0};
                end else begin
                    state_nxt = STATUS;
                end
            end
            IGNORE: begin
                oe_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Deselect wins over everything; an in-flight fetch is left to finish and discarded.
        if (cs_n_s && (state_r != IDLE)) begin
            state_nxt    = IDLE;
            oe_nxt       = 1'b0;
            miso_nxt     = 1'b1;
            pf_valid_nxt = 1'b0;
            stale_nxt    = rd_nxt;
        end else begin
            busy_nxt     = ~cs_n_s;
        end
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= 2'd0;
            shift_r     <= 8'h00;
            addr_r      <= 24'h000000;
            dummy_r     <= 1'b0;
            tx_r        <= 8'hFF;
            pf_r        <= 8'h00;
            pf_valid_r  <= 1'b0;
            stale_r     <= 1'b0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
            mem_rd_o    <= 1'b0;
            mem_adr_o   <= {ADDR_W{1'b0}};
            busy_o      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            byte_cnt_r  <= byte_cnt_nxt;
            shift_r     <= shift_nxt;
            addr_r      <= addr_nxt;
            dummy_r     <= dummy_nxt;
            tx_r        <= tx_nxt;
            pf_r        <= pf_nxt;
            pf_valid_r  <= pf_valid_nxt;
            stale_r     <= stale_nxt;
            spi_miso    <= miso_nxt;
            spi_miso_oe <= oe_nxt;
            mem_rd_o    <= rd_nxt;
            mem_adr_o   <= adr_nxt;
            busy_o      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: SPI master tasks, latency-randomized memory responder,
// table-driven directed transactions, corner sequences and random reads.
module tb_spi_flash_responder;

    localparam int ADDR_W = 21;
    localparam int H      = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs_n = 1'b1;
    logic              sclk = 1'b0;
    logic              mosi = 1'b0;
    logic              miso, oe, mem_rd, busy;
    logic [ADDR_W-1:0] mem_adr;
    logic [7:0]        mem_dat = 8'h00;
    logic              mem_ack = 1'b0;

    spi_flash_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .spi_cs_n(cs_n), .spi_sclk(sclk),
        .spi_mosi(mosi), .spi_miso(miso), .spi_miso_oe(oe), .mem_adr_o(mem_adr),
        .mem_rd_o(mem_rd), .mem_dat_i(mem_dat), .mem_ack_i(mem_ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] ovr[int];
    int   fetch_log[$];
    logic [7:0] rx_q[$];
    bit   rd_seen, dummy_oe, data_oe_all, data_oe_any;
    int   lat = 1;
    int   wcnt = 0;

    // Backing store: explicit overrides, otherwise an address-derived pattern.
    function automatic logic [7:0] mem_byte(input int a);
        if (ovr.exists(a)) return ovr[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Reference: byte i of a read at flash address a.
    function automatic logic [7:0] exp_byte(input logic [23:0] a, input int i);
        logic [23:0] t;
        t = a + 24'(i);
        return mem_byte(int'(t[ADDR_W-1:0]));
    endfunction

    function automatic int exp_fetch(input logic [23:0] a, input int i);
        logic [23:0] t;
        t = a + 24'(i);
        return int'(t[ADDR_W-1:0]);
    endfunction

    // Memory responder with random 0..3 cycle extra latency, one-cycle ack.
    always @(negedge clk) begin
        if (mem_rd) rd_seen = 1'b1;
        if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
            lat = $urandom_range(0, 3);
        end else if (mem_rd) begin
            if (wcnt >= lat) begin
                mem_ack = 1'b1;
                mem_dat = mem_byte(int'(mem_adr));
                fetch_log.push_back(int'(mem_adr));
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input int nbits,
                        output logic [7:0] rx, output bit any, output bit all);
        rx = 8'h00; any = 1'b0; all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            mosi = d[7-i];
            cyc(H);
            rx  = {rx[6:0], miso};
            any = any | oe;
            all = all & oe;
            sclk = 1'b1;
            cyc(H);
            sclk = 1'b0;
        end
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [23:0] a, input int nbytes);
        logic [7:0] r, ab;
        bit any, all;
        rx_q.delete();
        fetch_log.delete();
        rd_seen = 1'b0; dummy_oe = 1'b0; data_oe_all = 1'b1; data_oe_any = 1'b0;
        cs_n = 1'b0;
        cyc(H);
        xfer(op, 8, r, any, all);
        if (op == 8'h03 || op == 8'h0B) begin
            for (int k = 2; k >= 0; k--) begin
                ab = a[8*k +: 8];
                xfer(ab, 8, r, any, all);
            end
        end
        if (op == 8'h0B) begin
            xfer(8'h00, 8, r, any, all);
            dummy_oe = any;
        end
        for (int b = 0; b < nbytes; b++) begin
            xfer(8'($urandom), 8, r, any, all);
            rx_q.push_back(r);
            data_oe_all = data_oe_all & all;
            data_oe_any = data_oe_any | any;
        end
        cs_n = 1'b1;
        cyc(3*H);
    endtask

    task automatic check_read(input string tag, input logic [7:0] op, input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_byte(a, i)));
        chk({tag, "_oe"}, 32'(data_oe_all), 32'd1);
        if (op == 8'h0B) chk({tag, "_dummy_oe"}, 32'(dummy_oe), 32'd0);
        chk({tag, "_nfetch"}, 32'(fetch_log.size()), 32'(n + 1));
        for (int j = 0; j < fetch_log.size() && j <= n; j++)
            chk({tag, "_fetch"}, 32'(fetch_log[j]), 32'(exp_fetch(a, j)));
        chk({tag, "_adr"}, 32'(mem_adr), 32'(exp_fetch(a, n)));
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] a;
        int          n;
        logic [31:0] exp;
        logic [31:0] last_adr;
    } vec_t;

    vec_t vt[5];

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        bit any, all;
        logic [7:0] op;
        logic [23:0] a;
        int n;

        ovr[32'h100] = 8'hA5; ovr[32'h101] = 8'h5A; ovr[32'h102] = 8'hC3; ovr[32'h103] = 8'h3C;
        ovr[32'h10] = 8'h12; ovr[32'h11] = 8'h34;
        ovr[32'h1FFFFF] = 8'hE1; ovr[32'h0] = 8'h7E;
        ovr[32'h200] = 8'h96; ovr[32'h201] = 8'h69;

        vt[0] = '{8'h03, 24'h000100, 4, 32'hA55AC33C, 32'h104};
        vt[1] = '{8'h0B, 24'h000010, 2, 32'h1234_0000, 32'h12};
        vt[2] = '{8'h03, 24'h1FFFFF, 2, 32'hE17E_0000, 32'h1};
        vt[3] = '{8'h05, 24'h000000, 3, 32'h0000_0000, 32'h1};
        vt[4] = '{8'h9F, 24'h000000, 2, 32'h0000_0000, 32'h1};

        cyc(4);
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_adr", 32'(mem_adr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc(5);

        for (int v = 0; v < 5; v++) begin
            do_cmd(vt[v].op, vt[v].a, vt[v].n);
            if (vt[v].op == 8'h03 || vt[v].op == 8'h0B) begin
                for (int i = 0; i < vt[v].n; i++)
                    chk("tbl_byte", 32'(rx_q[i]), 32'(vt[v].exp[31-8*i -: 8]));
                chk("tbl_last_adr", 32'(mem_adr), vt[v].last_adr);
                check_read("tbl", vt[v].op, vt[v].a, vt[v].n);
            end else if (vt[v].op == 8'h05) begin
                for (int i = 0; i < vt[v].n; i++)
                    chk("rdsr_byte", 32'(rx_q[i]), 32'(vt[v].exp[31-8*i -: 8]));
                chk("rdsr_oe", 32'(data_oe_all), 32'd1);
                chk("rdsr_no_rd", 32'(rd_seen), 32'd0);
            end else begin
                chk("ign_oe", 32'(data_oe_any), 32'd0);
                chk("ign_no_rd", 32'(rd_seen), 32'd0);
                chk("ign_rd", 32'(mem_rd), 32'd0);
            end
        end

        // Deselect in the middle of a data byte.
        cs_n = 1'b0; cyc(H);
        xfer(8'h03, 8, r, any, all);
        xfer(8'h00, 8, r, any, all); xfer(8'h01, 8, r, any, all); xfer(8'h00, 8, r, any, all);
        xfer(8'h00, 8, r, any, all);
        chk("abort_first_byte", 32'(r), 32'hA5);
        xfer(8'h00, 3, r, any, all);
        cs_n = 1'b1;
        cyc(2);
        chk("abort_oe_before", 32'(oe), 32'd1);
        cyc(2);
        chk("abort_oe_after", 32'(oe), 32'd0);
        chk("abort_miso", 32'(miso), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        cyc(3*H);

        // Deselect after 5 address bits, then a clean read.
        cs_n = 1'b0; cyc(H);
        xfer(8'h03, 8, r, any, all);
        xfer(8'hFF, 5, r, any, all);
        cs_n = 1'b1; cyc(3*H);
        do_cmd(8'h03, 24'h000200, 2);
        chk("after_abort_b0", 32'(rx_q[0]), 32'h96);
        chk("after_abort_b1", 32'(rx_q[1]), 32'h69);
        check_read("after_abort", 8'h03, 24'h000200, 2);

        // Reset pulse in the middle of DATA.
        cs_n = 1'b0; cyc(H);
        xfer(8'h03, 8, r, any, all);
        xfer(8'h00, 8, r, any, all); xfer(8'h01, 8, r, any, all); xfer(8'h00, 8, r, any, all);
        xfer(8'h00, 8, r, any, all);
        xfer(8'h00, 4, r, any, all);
        rst = 1'b1;
        cyc(1);
        chk("mrst_oe", 32'(oe), 32'd0);
        chk("mrst_miso", 32'(miso), 32'd1);
        chk("mrst_rd", 32'(mem_rd), 32'd0);
        chk("mrst_adr", 32'(mem_adr), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc(H);
        chk("mrst_oe_hold", 32'(oe), 32'd0);
        chk("mrst_rd_hold", 32'(mem_rd), 32'd0);
        cs_n = 1'b1; cyc(3*H);
        do_cmd(8'h03, 24'h000101, 2);
        check_read("post_rst", 8'h03, 24'h000101, 2);

        // Random READ / FAST_READ transactions against the reference model.
        for (int t = 0; t < 8; t++) begin
            op = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B;
            a  = 24'($urandom);
            n  = $urandom_range(1, 4);
            do_cmd(op, a, n);
            check_read("rand", op, a, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
